// File: rtl/instr_encoder.sv
// Streaming MIPS instruction encoder: symbolic beat in, packed 32-bit word plus
// instruction-memory word address out, through a single-register output stage.
module instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [3:0]        kind_i,
  input  logic [4:0]        rs_i,
  input  logic [4:0]        rt_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        shamt_i,
  input  logic [5:0]        funct_i,
  input  logic [15:0]       imm_i,
  input  logic [25:0]       target_i,
  input  logic              last_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       out_instr_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic              out_last_o,
  output logic [1:0]        err_o,
  output logic              done_o
);

  typedef enum logic {S_RUN = 1'b0, S_DONE = 1'b1} state_t;

  // Bit 32 flags a legal kind; kinds 11-15 encode to zero and are flagged illegal.
  function automatic logic [32:0] f_encode(
    input logic [3:0]  kind,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [5:0]  funct,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [32:0] res;
    case (kind)
      4'd0:    res = {1'b1, 6'd0,  rs, rt, rd, shamt, funct};
      4'd1:    res = {1'b1, 6'd35, rs, rt, imm};
      4'd2:    res = {1'b1, 6'd43, rs, rt, imm};
      4'd3:    res = {1'b1, 6'd4,  rs, rt, imm};
      4'd4:    res = {1'b1, 6'd5,  rs, rt, imm};
      4'd5:    res = {1'b1, 6'd1,  rs, rt, imm};
      4'd6:    res = {1'b1, 6'd7,  rs, rt, imm};
      4'd7:    res = {1'b1, 6'd8,  rs, rt, imm};
      4'd8:    res = {1'b1, 6'd10, rs, rt, imm};
      4'd9:    res = {1'b1, 6'd2,  target};
      4'd10:   res = {1'b1, 6'd3,  target};
      default: res = {1'b0, 32'd0};
    endcase
    return res;
  endfunction

  state_t              r_state;
  logic                r_out_valid;
  logic [31:0]         r_out_instr;
  logic [ADDR_W-1:0]   r_out_addr;
  logic                r_out_last;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_err;
  logic                r_done;

  logic [32:0]         w_enc;
  logic                w_accept;
  logic                w_load;
  logic                w_valid_nxt;
  state_t              w_state_nxt;

  assign in_ready_o  = rst_i && (r_state == S_RUN) && (!r_out_valid || out_ready_i);
  assign w_accept    = in_valid_i && in_ready_o;
  assign w_enc       = f_encode(kind_i, rs_i, rt_i, rd_i, shamt_i, funct_i, imm_i, target_i);
  assign w_load      = w_accept && w_enc[32];

  assign out_valid_o = r_out_valid;
  assign out_instr_o = r_out_instr;
  assign out_addr_o  = r_out_addr;
  assign out_last_o  = r_out_last;
  assign err_o       = r_err;
  assign done_o      = r_done;

  // Next-state and next output-valid; done is registered from these next values.
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_out_valid;
    if (w_load) begin
      w_valid_nxt = 1'b1;
    end else if (out_ready_i) begin
      w_valid_nxt = 1'b0;
    end else begin
      w_valid_nxt = r_out_valid;
    end
    case (r_state)
      S_RUN: begin
        if (w_accept && last_i) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_RUN;
    endcase
  end

  // State, output stage, address counter and sticky error flags.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state     <= S_RUN;
      r_out_valid <= 1'b0;
      r_out_instr <= 32'd0;
      r_out_addr  <= {ADDR_W{1'b0}};
      r_out_last  <= 1'b0;
      r_addr      <= ADDR_W'(BASE_ADDR);
      r_err       <= 2'b00;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= w_valid_nxt;
      r_done      <= (w_state_nxt == S_DONE) && !w_valid_nxt;
      if (w_load) begin
        r_out_instr <= w_enc[31:0];
        r_out_addr  <= r_addr;
        r_out_last  <= last_i;
        r_addr      <= r_addr + ADDR_W'(1);
        if (r_addr == {ADDR_W{1'b1}}) begin
          r_err[1] <= 1'b1;
        end
      end
      if (w_accept && !w_enc[32]) begin
        r_err[0] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: two instances (ADDR_W=8 and ADDR_W=2) share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic [3:0]  kind_i = 4'd0;
  logic [4:0]  rs_i = 5'd0, rt_i = 5'd0, rd_i = 5'd0, shamt_i = 5'd0;
  logic [5:0]  funct_i = 6'd0;
  logic [15:0] imm_i = 16'd0;
  logic [25:0] target_i = 26'd0;
  logic        last_i = 1'b0;
  logic        out_ready_i = 1'b1;

  logic        ir_a, ov_a, ol_a, dn_a;
  logic [31:0] oi_a;
  logic [7:0]  oa_a;
  logic [1:0]  er_a;
  logic        ir_b, ov_b, ol_b, dn_b;
  logic [31:0] oi_b;
  logic [1:0]  oa_b;
  logic [1:0]  er_b;

  int n_vec = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(ir_a),
    .kind_i(kind_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .shamt_i(shamt_i),
    .funct_i(funct_i), .imm_i(imm_i), .target_i(target_i), .last_i(last_i),
    .out_valid_o(ov_a), .out_ready_i(out_ready_i), .out_instr_o(oi_a),
    .out_addr_o(oa_a), .out_last_o(ol_a), .err_o(er_a), .done_o(dn_a));

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(ir_b),
    .kind_i(kind_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .shamt_i(shamt_i),
    .funct_i(funct_i), .imm_i(imm_i), .target_i(target_i), .last_i(last_i),
    .out_valid_o(ov_b), .out_ready_i(out_ready_i), .out_instr_o(oi_b),
    .out_addr_o(oa_b), .out_last_o(ol_b), .err_o(er_b), .done_o(dn_b));

  // Behavioural model state
  int unsigned op_tab[11] = '{0, 35, 43, 4, 5, 1, 7, 8, 10, 2, 3};
  bit          m_valid = 0, m_last = 0, m_done_st = 0, m_acc = 0;
  int unsigned m_instr = 0;
  int          m_addr_a = 0, m_addr_b = 0, m_cnt_a = 0, m_cnt_b = 0;
  bit [1:0]    m_err_a = 0, m_err_b = 0;

  function automatic int unsigned model_word(input int k);
    int unsigned op = op_tab[k];
    if (k == 0)
      return (int'(rs_i) << 21) + (int'(rt_i) << 16) + (int'(rd_i) << 11)
           + (int'(shamt_i) << 6) + int'(funct_i);
    else if (k == 9 || k == 10)
      return op * 32'd67108864 + int'(target_i);
    else
      return op * 32'd67108864 + (int'(rs_i) << 21) + (int'(rt_i) << 16) + int'(imm_i);
  endfunction

  task automatic model_edge();
    bit rdy;
    m_acc = 0;
    if (!rst_i) begin
      m_valid = 0; m_instr = 0; m_addr_a = 0; m_addr_b = 0; m_last = 0;
      m_err_a = 0; m_err_b = 0; m_done_st = 0; m_cnt_a = 0; m_cnt_b = 0;
    end else begin
      rdy = !m_done_st && (!m_valid || out_ready_i);
      m_acc = in_valid_i && rdy;
      if (m_acc && kind_i <= 4'd10) begin
        m_valid = 1; m_instr = model_word(int'(kind_i)); m_last = last_i;
        m_addr_a = m_cnt_a; m_addr_b = m_cnt_b;
        if (m_cnt_a + 1 == 256) m_err_a[1] = 1;
        if (m_cnt_b + 1 == 4)   m_err_b[1] = 1;
        m_cnt_a = (m_cnt_a + 1) % 256;
        m_cnt_b = (m_cnt_b + 1) % 4;
      end else begin
        if (m_acc) begin m_err_a[0] = 1; m_err_b[0] = 1; end
        if (out_ready_i) m_valid = 0;
      end
      if (m_acc && last_i) m_done_st = 1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_cycle();
    bit exp_rdy = rst_i && !m_done_st && (!m_valid || out_ready_i);
    bit exp_done = m_done_st && !m_valid;
    chk("in_ready_a", 32'(ir_a), 32'(exp_rdy));
    chk("in_ready_b", 32'(ir_b), 32'(exp_rdy));
    chk("out_valid_a", 32'(ov_a), 32'(m_valid));
    chk("out_valid_b", 32'(ov_b), 32'(m_valid));
    chk("done_a", 32'(dn_a), 32'(exp_done));
    chk("done_b", 32'(dn_b), 32'(exp_done));
    chk("err_a", 32'(er_a), 32'(m_err_a));
    chk("err_b", 32'(er_b), 32'(m_err_b));
    if (m_valid) begin
      chk("instr_a", oi_a, m_instr);
      chk("instr_b", oi_b, m_instr);
      chk("addr_a", 32'(oa_a), m_addr_a);
      chk("addr_b", 32'(oa_b), m_addr_b);
      chk("last_a", 32'(ol_a), 32'(m_last));
      chk("last_b", 32'(ol_b), 32'(m_last));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b0; in_valid_i = 1'b0;
    tick(); tick();
    rst_i = 1'b1;
  endtask

  task automatic set_beat(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm,
                          input logic [25:0] tgt, input logic lst);
    kind_i = k; rs_i = rs; rt_i = rt; rd_i = rd; shamt_i = 5'd0; funct_i = fn;
    imm_i = imm; target_i = tgt; last_i = lst; in_valid_i = 1'b1;
  endtask

  task automatic send(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic lst);
    bit got = 0;
    set_beat(k, rs, rt, rd, fn, imm, tgt, lst);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_acc) begin got = 1; break; end
    end
    n_vec++;
    if (!got) begin
      n_fail++;
      $display("FAIL send_timeout: kind %0d not accepted within 20 cycles", k);
    end
    in_valid_i = 1'b0; last_i = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_valid", 32'(ov_a), 32'd0);
    chk("rst_instr", oi_a, 32'd0);
    chk("rst_err", 32'(er_a), 32'd0);

    // Single beats
    out_ready_i = 1'b1;
    send(4'd7, 5'd0, 5'd8, 5'd0, 6'd0, 16'd5, 26'd0, 1'b0);
    chk("lit_addi", oi_a, 32'h20080005);
    chk("lit_addi_addr", 32'(oa_a), 32'd0);
    tick();
    send(4'd0, 5'd9, 5'd10, 5'd8, 6'h20, 16'd0, 26'd0, 1'b0);
    chk("lit_r", oi_a, 32'h012A4020);
    chk("lit_r_addr", 32'(oa_a), 32'd1);

    // Back-to-back, no bubbles
    send(4'd1, 5'd29, 5'd8, 5'd0, 6'd0, 16'd4, 26'd0, 1'b0);
    chk("lit_lw", oi_a, 32'h8FA80004);
    chk("lit_lw_addr", 32'(oa_a), 32'd2);
    send(4'd3, 5'd8, 5'd9, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b0);
    chk("lit_beq", oi_a, 32'h1109FFFF);
    chk("lit_beq_addr", 32'(oa_a), 32'd3);
    send(4'd5, 5'd4, 5'd5, 5'd0, 6'd0, 16'd2, 26'd0, 1'b0);
    chk("lit_bge", oi_a, 32'h04850002);
    chk("lit_bge_addr", 32'(oa_a), 32'd4);

    // Backpressure while j is held
    send(4'd9, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10, 1'b0);
    out_ready_i = 1'b0;
    set_beat(4'd10, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h40, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lit_j_hold", oi_a, 32'h08000010);
      chk("lit_j_ready", 32'(ir_a), 32'd0);
    end
    out_ready_i = 1'b1;
    send(4'd10, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h40, 1'b0);
    chk("lit_jal", oi_a, 32'h0C000040);
    chk("lit_jal_addr", 32'(oa_a), 32'd6);
    tick();

    // Illegal kind between two addi beats
    do_reset();
    send(4'd7, 5'd0, 5'd8, 5'd0, 6'd0, 16'd5, 26'd0, 1'b0);
    send(4'd12, 5'd1, 5'd2, 5'd3, 6'd0, 16'd7, 26'd0, 1'b0);
    chk("lit_ill_err", 32'(er_a), 32'd1);
    chk("lit_ill_valid", 32'(ov_a), 32'd0);
    send(4'd7, 5'd0, 5'd8, 5'd0, 6'd0, 16'd6, 26'd0, 1'b0);
    chk("lit_ill_addr", 32'(oa_a), 32'd1);
    chk("lit_ill_instr", oi_a, 32'h20080006);
    tick();

    // Address wrap on the ADDR_W=2 instance
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(4'd7, 5'd1, 5'd2, 5'd0, 6'd0, 16'(i), 26'd0, 1'b0);
      chk("lit_wrap_addr", 32'(oa_b), 32'(i % 4));
      if (i == 2) chk("lit_wrap_err_pre", 32'(er_b), 32'd0);
      if (i == 3) chk("lit_wrap_err", 32'(er_b), 32'd2);
    end
    chk("lit_wide_addr", 32'(oa_a), 32'd4);
    tick();

    // Last beat, drain and done
    do_reset();
    out_ready_i = 1'b0;
    send(4'd10, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h123, 1'b1);
    chk("lit_last", 32'(ol_a), 32'd1);
    chk("lit_last_ready", 32'(ir_a), 32'd0);
    chk("lit_last_done_pre", 32'(dn_a), 32'd0);
    tick();
    out_ready_i = 1'b1;
    tick();
    chk("lit_done", 32'(dn_a), 32'd1);
    tick();

    // Reset in the middle of a held word
    do_reset();
    send(4'd12, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
    out_ready_i = 1'b0;
    send(4'd7, 5'd0, 5'd8, 5'd0, 6'd0, 16'd9, 26'd0, 1'b0);
    tick();
    chk("lit_hold_valid", 32'(ov_a), 32'd1);
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    chk("lit_mid_rst_valid", 32'(ov_a), 32'd0);
    chk("lit_mid_rst_err", 32'(er_a), 32'd0);
    chk("lit_mid_rst_done", 32'(dn_a), 32'd0);
    out_ready_i = 1'b1;
    send(4'd7, 5'd1, 5'd8, 5'd0, 6'd0, 16'd1, 26'd0, 1'b0);
    chk("lit_base_addr", 32'(oa_a), 32'd0);
    chk("lit_base_instr", oi_a, 32'h20280001);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
